// File: rtl/tx_seq_pkg.sv
// Shared constants for the TX nibble sequencer: register addresses, CONTROL/STATUS
// bit positions, engine state type and the nibble-select helper.
package tx_seq_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_IRQ  = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_MSB_FIRST = 1;
  localparam int CTRL_DIV_LSB   = 16;

  localparam int STAT_LEVEL_W = 8;
  localparam int STAT_BUSY    = 8;
  localparam int STAT_OVF     = 9;
  localparam int STAT_FULL    = 10;
  localparam int STAT_EMPTY   = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // idx counts nibbles in transmit order; msb_first flips which end goes out first.
  function automatic logic [3:0] sel_nibble(input logic [31:0] word,
                                            input logic [2:0]  idx,
                                            input logic        msb_first);
    logic [2:0] pos;
    pos = msb_first ? (3'd7 - idx) : idx;
    return word[{pos, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/tx_nibble_sequencer_if.sv
// Avalon-MM register bus of the TX nibble sequencer; master drives the
// request, slave returns the combinational readdata.
interface tx_nibble_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tx_seq_fifo.sv
// Synchronous word FIFO, registered push, combinational head; level/full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module tx_seq_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/tx_nibble_sequencer.sv
// Buffers 32-bit TX words and shifts each out as 8 nibbles, DIV+1 cycles each; first nibble 2 cycles
// after a DATA write to an idle engine; full-FIFO writes drop and set OVF. TX_IRQ_EN adds IRQ_MASK/irq.
module tx_nibble_sequencer
  import tx_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tx_nibble_sequencer_if.slave bus,
  output logic [3:0]           out_port,
  output logic                 out_strobe,
  output logic                 busy
`ifdef TX_IRQ_EN
  ,
  output logic                 irq
`endif
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_en;
  logic             push;
  logic             pop;
  logic             load;
  logic             advance;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      fifo_head;

  logic             ctrl_enable;
  logic             ctrl_msb_first;
  logic [DIV_W-1:0] ctrl_div;
  logic             ovf;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      shreg;
  logic [2:0]       nib_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             msb_first;
  logic             first_cyc;
  logic [3:0]       last_nib;
  logic [3:0]       cur_nib;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign push  = wr_en && (bus.address == ADDR_DATA);

  tx_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (bus.writedata),
    .dout    (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable    <= 1'b0;
      ctrl_msb_first <= 1'b0;
      ctrl_div       <= '0;
      ovf            <= 1'b0;
    end else begin
      if (wr_en && bus.address == ADDR_CTRL) begin
        ctrl_enable    <= bus.writedata[CTRL_ENABLE];
        ctrl_msb_first <= bus.writedata[CTRL_MSB_FIRST];
        ctrl_div       <= bus.writedata[CTRL_DIV_LSB +: DIV_W];
      end
      // Full-FIFO write is only lost when the engine is not popping that same cycle.
      if (push && fifo_full && !pop)
        ovf <= 1'b1;
      else if (wr_en && bus.address == ADDR_STAT && bus.writedata[STAT_OVF])
        ovf <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_enable && !fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == '0) begin
          if (nib_cnt != 3'd7) begin
            advance = 1'b1;
          end else if (ctrl_enable && !fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      nib_cnt   <= '0;
      div_cnt   <= '0;
      msb_first <= 1'b0;
      first_cyc <= 1'b0;
      last_nib  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shreg     <= fifo_head;
        nib_cnt   <= '0;
        div_cnt   <= ctrl_div;
        msb_first <= ctrl_msb_first;
        first_cyc <= 1'b1;
      end else if (advance) begin
        nib_cnt   <= nib_cnt + 1'b1;
        div_cnt   <= ctrl_div;
        first_cyc <= 1'b1;
      end else if (state == SHIFT) begin
        div_cnt   <= div_cnt - 1'b1;
        first_cyc <= 1'b0;
      end
      if (state == SHIFT) last_nib <= cur_nib;
    end
  end

  assign cur_nib    = sel_nibble(shreg, nib_cnt, msb_first);
  assign busy       = (state == SHIFT);
  assign out_port   = busy ? cur_nib : last_nib;
  assign out_strobe = busy & first_cyc;

`ifdef TX_IRQ_EN
  logic [1:0] irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && bus.address == ADDR_IRQ) irq_mask <= bus.writedata[1:0];
      irq <= (irq_mask[0] & fifo_empty & ~busy) | (irq_mask[1] & ovf);
    end
  end
`endif

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        bus.readdata[CTRL_ENABLE]             = ctrl_enable;
        bus.readdata[CTRL_MSB_FIRST]          = ctrl_msb_first;
        bus.readdata[CTRL_DIV_LSB +: DIV_W]   = ctrl_div;
      end
      ADDR_STAT: begin
        bus.readdata[STAT_LEVEL_W-1:0] = STAT_LEVEL_W'(fifo_level);
        bus.readdata[STAT_BUSY]        = busy;
        bus.readdata[STAT_OVF]         = ovf;
        bus.readdata[STAT_FULL]        = fifo_full;
        bus.readdata[STAT_EMPTY]       = fifo_empty;
      end
`ifdef TX_IRQ_EN
      ADDR_IRQ: bus.readdata[1:0] = irq_mask;
`else
      ADDR_IRQ: bus.readdata = '0;
`endif
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_tx_nibble_sequencer.sv
// Directed bench for tx_nibble_sequencer with a nibble-schedule model checked every cycle.
module tb_tx_nibble_sequencer;
  import tx_seq_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] out_port;
  logic       out_strobe;
  logic       busy;
`ifdef TX_IRQ_EN
  logic       irq;
`endif

  tx_nibble_sequencer_if bus_if ();

  tx_nibble_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .busy       (busy)
`ifdef TX_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: word queue plus a per-cycle schedule of (nibble, strobe) for the word in flight.
  logic [31:0] mq [$];
  logic [3:0]  nq [$];
  bit          sq [$];
  bit          m_en;
  bit          m_msb;
  bit   [15:0] m_div;
  bit          m_ovf;
  logic [3:0]  m_last = 4'h0;
  logic [31:0] m_word;
  logic [3:0]  m_nib;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); nq.delete(); sq.delete();
      m_en = 0; m_msb = 0; m_div = 0; m_ovf = 0; m_last = 4'h0;
    end else begin
      if (nq.size() > 0) begin
        m_last = nq.pop_front();
        void'(sq.pop_front());
      end
      if (nq.size() == 0 && m_en && mq.size() > 0) begin
        m_word = mq.pop_front();
        for (int k = 0; k < 8; k++) begin
          m_nib = m_msb ? m_word[(7-k)*4 +: 4] : m_word[k*4 +: 4];
          for (int c = 0; c <= int'(m_div); c++) begin
            nq.push_back(m_nib);
            sq.push_back(c == 0);
          end
        end
      end
      if (bus_if.chipselect && !bus_if.write_n) begin
        case (bus_if.address)
          2'd0: if (mq.size() < DEPTH) mq.push_back(bus_if.writedata); else m_ovf = 1;
          2'd1: begin
            m_en  = bus_if.writedata[0];
            m_msb = bus_if.writedata[1];
            m_div = bus_if.writedata[31:16];
          end
          2'd2: if (bus_if.writedata[9]) m_ovf = 0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && reset_n) begin
      if (nq.size() > 0) begin
        check("cyc_busy", {31'd0, busy}, 32'd1);
        check("cyc_out_port", {28'd0, out_port}, {28'd0, nq[0]});
        check("cyc_strobe", {31'd0, out_strobe}, {31'd0, sq[0]});
      end else begin
        check("cyc_busy", {31'd0, busy}, 32'd0);
        check("cyc_out_port", {28'd0, out_port}, {28'd0, m_last});
        check("cyc_strobe", {31'd0, out_strobe}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #2;
    check(name, bus_if.readdata, exp);
    bus_if.chipselect = 1'b0;
  endtask

  logic [3:0] seq_ab [16] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5,
                              4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    step(3);
    reset_n = 1'b1;
    run_cmp = 1'b1;

    // Reset state
    rd(ADDR_DATA, 32'h0, "rst_data");
    rd(ADDR_CTRL, 32'h0, "rst_ctrl");
    rd(ADDR_STAT, 32'h0000_0800, "rst_stat");
    rd(ADDR_IRQ,  32'h0, "rst_irq");
    check("rst_out_port", {28'd0, out_port}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // DIV=0, LSB first: one nibble per cycle starting two cycles after the write
    wr(ADDR_CTRL, 32'h0000_0001);
    wr(ADDR_DATA, 32'h8765_4321);
    step(1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("div0_nib%0d", i), {28'd0, out_port}, 32'(i + 1));
      check($sformatf("div0_stb%0d", i), {31'd0, out_strobe}, 32'd1);
      step(1);
    end
    check("div0_idle_busy", {31'd0, busy}, 32'd0);
    check("div0_hold", {28'd0, out_port}, 32'd8);

    // DIV=3, MSB first, two words back to back
    wr(ADDR_CTRL, 32'h0003_0003);
    rd(ADDR_CTRL, 32'h0003_0003, "ctrl_readback");
    wr(ADDR_DATA, 32'hA5A5_A5A5);
    wr(ADDR_DATA, 32'h0F0F_0F0F);
    for (int j = 0; j < 64; j++) begin
      check($sformatf("div3_nib%0d", j), {28'd0, out_port}, {28'd0, seq_ab[j/4]});
      check($sformatf("div3_stb%0d", j), {31'd0, out_strobe}, 32'((j % 4) == 0));
      step(1);
    end
    check("div3_done_busy", {31'd0, busy}, 32'd0);

    // Overflow with engine disabled
    wr(ADDR_CTRL, 32'h0000_0000);
    for (int i = 0; i < 9; i++) wr(ADDR_DATA, 32'h100 + i);
    rd(ADDR_STAT, 32'h0000_0608, "ovf_stat");
    wr(ADDR_STAT, 32'h0000_0200);
    rd(ADDR_STAT, 32'h0000_0408, "ovf_clear");

    // Drop ENABLE during nibble 3 of word 0x100 (DIV=1, LSB first)
    wr(ADDR_CTRL, 32'h0001_0001);
    step(5);
    check("en_nib2", {28'd0, out_port}, 32'd1);
    check("en_nib2_stb", {31'd0, out_strobe}, 32'd1);
    step(2);
    wr(ADDR_CTRL, 32'h0001_0000);
    step(10);
    check("en_drop_idle", {31'd0, busy}, 32'd0);
    rd(ADDR_STAT, 32'h0000_0007, "en_drop_level");
    step(4);
    check("en_drop_stay", {31'd0, busy}, 32'd0);
    rd(ADDR_STAT, 32'h0000_0007, "en_drop_kept");

    // Reset mid-word
    wr(ADDR_CTRL, 32'h0001_0001);
    step(1);
    check("mid_nib0", {28'd0, out_port}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_out_port", {28'd0, out_port}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_strobe", {31'd0, out_strobe}, 32'd0);
    step(2);
    reset_n = 1'b1;
    rd(ADDR_STAT, 32'h0000_0800, "arst_stat");
    rd(ADDR_CTRL, 32'h0, "arst_ctrl");

`ifdef TX_IRQ_EN
    wr(ADDR_IRQ, 32'h1);
    rd(ADDR_IRQ, 32'h1, "irq_mask_rb");
    step(2);
    check("irq_empty", {31'd0, irq}, 32'd1);
    wr(ADDR_DATA, 32'h1);
    step(1);
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif

    step(2);
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
